axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite initiator.
- Converts a simple valid/ready command/response interface into AXI4-Lite read and write transactions.
- Drives the s_axi_* port set of AXI-Lite register blocks such as the Nexys Video GPIO block design, so firmware-less test logic and on-chip sequencers can program LEDs and read status.
- Sits between a local controller and the AXI-Lite interconnect or slave.

Parameters:
- AXI_ALEN, 64, address width in bits.
- AXI_DLEN, 64, data width in bits.
- AXI_SLEN, AXI_DLEN/8, write strobe width.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command request valid.
- o_cmd_ready  out  1  block idle, command accepted on valid&&ready.
- i_cmd_we  in  1  1=write, 0=read.
- i_cmd_addr  in  AXI_ALEN  absolute byte address.
- i_cmd_wdata  in  AXI_DLEN  write data (ignored for reads).
- i_cmd_wstrb  in  AXI_SLEN  write strobes (ignored for reads).
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed.
- o_rsp_rdata  out  AXI_DLEN  read data; 0 for writes.
- o_rsp_resp  out  2  BRESP/RRESP of the transaction.
- o_rsp_we  out  1  echo of i_cmd_we for the response.
- m_axi_awvalid/awready/awaddr[AXI_ALEN]/awprot[3]  AW channel (master side).
- m_axi_wvalid/wready/wdata[AXI_DLEN]/wstrb[AXI_SLEN]  W channel.
- m_axi_bvalid/bready/bresp[2]  B channel.
- m_axi_arvalid/arready/araddr[AXI_ALEN]/arprot[3]  AR channel.
- m_axi_rvalid/rready/rdata[AXI_DLEN]/rresp[2]  R channel.

Behaviour:
- Reset (async assert, sync release): state=IDLE. Every output is 0, including o_cmd_ready, all m_axi valids, bready, rready, o_rsp_*, and the address/data/strb registers. o_cmd_ready rises on the first aclk edge after aresetn deasserts.
- All outputs are registered. awprot/arprot are constant 3'b000. awaddr/araddr = latched i_cmd_addr, unmodified.
- State machine IDLE -> WR -> WB -> RSP, or IDLE -> RD_AR -> RD_R -> RSP, then RSP -> IDLE.
- IDLE: o_cmd_ready=1. On i_cmd_valid&&o_cmd_ready, latch addr/wdata/wstrb/we and drop o_cmd_ready next cycle.
  - we=1: assert awvalid and wvalid next cycle, go WR.
  - we=0: assert arvalid next cycle, go RD_AR.
- WR: awvalid and wvalid are held independently until their own handshake, then deasserted the following cycle. Done flags track each channel.
  - AW and W may complete in the same cycle or in either order.
  - When both are done, assert bready next cycle and go WB.
- WB: on bvalid&&bready: deassert bready, set o_rsp_resp=bresp, o_rsp_rdata=0, o_rsp_we=1, o_rsp_valid=1, go RSP.
- RD_AR: hold arvalid until arready. Then deassert arvalid, assert rready next cycle, go RD_R.
- RD_R: on rvalid&&rready: deassert rready, capture rdata/rresp into o_rsp_*, o_rsp_we=0, o_rsp_valid=1, go RSP.
- RSP: o_rsp_* stable while o_rsp_valid && !i_rsp_ready. On handshake, o_rsp_valid=0 and o_cmd_ready=1 next cycle (IDLE).
- bvalid/rvalid arriving early (before bready/rready) are handled correctly; the slave holds them per AXI.
- Valids never drop before their handshake. Payloads are stable while valid is high.
- Minimum latency, zero-wait slave (accept at edge 0):
  - write: AW/W valid cycle 1, bready cycle 2, o_rsp_valid cycle 3.
  - read: arvalid cycle 1, rready cycle 2, o_rsp_valid cycle 3.
  - back-to-back command throughput: one per 4 cycles.
- Only one transaction is outstanding; no commands are accepted until the response is consumed.
- SLVERR/DECERR are passed through in o_rsp_resp, with no retry.
- aresetn asserted mid-transaction aborts immediately: all valids/readies drop asynchronously and the pending response is discarded.

Test Plan:
- Write addr 0x0, wdata 0xA5, wstrb 0x01; zero-wait slave -> awaddr=0, wdata=0xA5 on cycle 1; o_rsp_valid cycle 3, resp=00, rdata=0, o_rsp_we=1.
- Read addr 0x0; slave returns rdata 0x1234, rresp 00 after 2-cycle arready and 3-cycle rvalid stalls -> arvalid held for the 2 stall cycles; o_rsp_rdata=0x1234, resp=00, o_rsp_we=0.
- Write with awready 4 cycles late and wready immediate (then the reverse) -> wvalid drops after 1 cycle, awvalid held 4 cycles; bready only after both handshakes; exactly one response.
- Slave returns bresp=2'b10 -> o_rsp_resp=2'b10. Hold i_rsp_ready=0 for 5 cycles -> response stable and o_cmd_ready=0 throughout; a new command is accepted only after the handshake.
- Back-to-back write then read with i_cmd_valid constant -> second command accepted exactly one cycle after the first response handshake; no AXI overlap.
- Assert aresetn low while awvalid=1 -> awvalid/wvalid=0 immediately and no o_rsp_valid. After release, o_cmd_ready=1 on the next edge and a new read completes normally.

Source files
------------

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite initiator.
// Turns a valid/ready command/response pair into one AXI4-Lite read or
// write at a time. Every output comes straight from a flop.
module axil_cmd_master #(
    parameter int AXI_ALEN = 64,
    parameter int AXI_DLEN = 64,
    parameter int AXI_SLEN = AXI_DLEN / 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    // command side
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_we,
    input  logic [AXI_ALEN-1:0] i_cmd_addr,
    input  logic [AXI_DLEN-1:0] i_cmd_wdata,
    input  logic [AXI_SLEN-1:0] i_cmd_wstrb,
    // response side
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [AXI_DLEN-1:0] o_rsp_rdata,
    output logic [1:0]          o_rsp_resp,
    output logic                o_rsp_we,
    // AW channel
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [AXI_ALEN-1:0] m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    // W channel
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [AXI_DLEN-1:0] m_axi_wdata,
    output logic [AXI_SLEN-1:0] m_axi_wstrb,
    // B channel
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    // AR channel
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [AXI_ALEN-1:0] m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    // R channel
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic [AXI_DLEN-1:0] m_axi_rdata,
    input  logic [1:0]          m_axi_rresp
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WB    = 3'd2;
    localparam logic [2:0] S_RD_AR = 3'd3;
    localparam logic [2:0] S_RD_R  = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    logic [2:0]          r_state;
    logic                r_cmd_ready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_aw_done;
    logic                r_w_done;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic [AXI_ALEN-1:0] r_addr;
    logic [AXI_DLEN-1:0] r_wdata;
    logic [AXI_SLEN-1:0] r_wstrb;
    logic                r_rsp_valid;
    logic [AXI_DLEN-1:0] r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_we;

    // Per-channel handshakes and the done flags as they will be after this edge,
    // so AW and W may finish together or in either order.
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done_nxt;
    logic w_w_done_nxt;
    assign w_aw_hs       = r_awvalid & m_axi_awready;
    assign w_w_hs        = r_wvalid & m_axi_wready;
    assign w_aw_done_nxt = r_aw_done | w_aw_hs;
    assign w_w_done_nxt  = r_w_done | w_w_hs;

    // Transaction sequencer: accepts a command, runs the AXI channels, holds the response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_addr      <= {AXI_ALEN{1'b0}};
            r_wdata     <= {AXI_DLEN{1'b0}};
            r_wstrb     <= {AXI_SLEN{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {AXI_DLEN{1'b0}};
            r_rsp_resp  <= 2'b00;
            r_rsp_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= i_cmd_addr;
                        r_wdata     <= i_cmd_wdata;
                        r_wstrb     <= i_cmd_wstrb;
                        if (i_cmd_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_AR;
                        end
                    end else begin
                        // first edge out of reset, or idle waiting for a command
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_WR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done_nxt;
                    r_w_done  <= w_w_done_nxt;
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WB;
                    end
                end
                S_WB: begin
                    if (m_axi_bvalid && r_bready) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axi_bresp;
                        r_rsp_rdata <= {AXI_DLEN{1'b0}};
                        r_rsp_we    <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RD_AR: begin
                    if (r_arvalid && m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (m_axi_rvalid && r_rready) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= m_axi_rresp;
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_we    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (r_rsp_valid && i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    // unreachable encoding: drop every handshake and resync to idle
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b0;
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_bready    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_resp    = r_rsp_resp;
    assign o_rsp_we      = r_rsp_we;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_bready  = r_bready;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: the bench plays the AXI slave by hand,
// cycle by cycle, and compares against hand-computed expectations.
module tb_axil_cmd_master;

    logic        aclk;
    logic        aresetn;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [63:0] i_cmd_addr;
    logic [63:0] i_cmd_wdata;
    logic [7:0]  i_cmd_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [63:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_rsp_we;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [63:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;

    int n_cmp;
    int n_err;

    axil_cmd_master dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp), .o_rsp_we(o_rsp_we),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    // 10 ns clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // advance one clock and settle just after the active edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_cmd(input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wstrb);
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        i_cmd_wstrb = wstrb;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = 64'd0;
        i_cmd_wdata = 64'd0; i_cmd_wstrb = 8'd0; i_rsp_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        m_axi_rdata = 64'd0; m_axi_rresp = 2'b00;
        tick(); tick(); tick();
        n_cmp++; if ({o_cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, o_rsp_valid} !== 7'b0) begin n_err++; $display("FAIL rst_ctrl got=%b exp=0", {o_cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, o_rsp_valid}); end
        n_cmp++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, o_rsp_rdata, o_rsp_resp, o_rsp_we} !== 203'd0) begin n_err++; $display("FAIL rst_data awaddr=%h wdata=%h rsp=%h", m_axi_awaddr, m_axi_wdata, o_rsp_rdata); end
        aresetn = 1'b1;
        #1;
        n_cmp++; if (o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_release_ready got=%b exp=0", o_cmd_ready); end
        tick();
        n_cmp++; if (o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_first_edge_ready got=%b exp=1", o_cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        set_cmd(1'b1, 64'h0, 64'hA5, 8'h01);
        tick();  // edge 0: accept
        i_cmd_valid = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, o_cmd_ready} !== 3'b110) begin n_err++; $display("FAIL wr0_c1_valids got=%b exp=110", {m_axi_awvalid, m_axi_wvalid, o_cmd_ready}); end
        n_cmp++; if (m_axi_awaddr !== 64'h0 || m_axi_wdata !== 64'hA5 || m_axi_wstrb !== 8'h01) begin n_err++; $display("FAIL wr0_c1_payload addr=%h data=%h strb=%h exp 0/a5/01", m_axi_awaddr, m_axi_wdata, m_axi_wstrb); end
        n_cmp++; if (m_axi_awprot !== 3'b000 || m_axi_arprot !== 3'b000) begin n_err++; $display("FAIL prot aw=%b ar=%b exp=000", m_axi_awprot, m_axi_arprot); end
        tick();  // edge 1: AW and W handshakes
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin n_err++; $display("FAIL wr0_c2 got=%b exp=001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        tick();  // edge 2: B handshake
        m_axi_bvalid = 1'b0;
        n_cmp++; if ({o_rsp_valid, m_axi_bready, o_rsp_we} !== 3'b101) begin n_err++; $display("FAIL wr0_c3 got=%b exp=101", {o_rsp_valid, m_axi_bready, o_rsp_we}); end
        n_cmp++; if (o_rsp_resp !== 2'b00 || o_rsp_rdata !== 64'd0) begin n_err++; $display("FAIL wr0_rsp resp=%b rdata=%h exp 00/0", o_rsp_resp, o_rsp_rdata); end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        n_cmp++; if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin n_err++; $display("FAIL wr0_done got=%b exp=01", {o_rsp_valid, o_cmd_ready}); end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    endtask

    task automatic test_read_stall();
        set_cmd(1'b0, 64'h0, 64'h0, 8'h00);
        tick();
        i_cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h0) begin n_err++; $display("FAIL rd_ar_hold%0d arvalid=%b araddr=%h exp 1/0", k, m_axi_arvalid, m_axi_araddr); end
            tick();
        end
        n_cmp++; if ({m_axi_arvalid, m_axi_rready} !== 2'b10) begin n_err++; $display("FAIL rd_ar_last got=%b exp=10", {m_axi_arvalid, m_axi_rready}); end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        n_cmp++; if ({m_axi_arvalid, m_axi_rready} !== 2'b01) begin n_err++; $display("FAIL rd_ar_done got=%b exp=01", {m_axi_arvalid, m_axi_rready}); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if ({m_axi_rready, o_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL rd_r_wait%0d got=%b exp=10", k, {m_axi_rready, o_rsp_valid}); end
        end
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'h1234; m_axi_rresp = 2'b00;
        tick();
        m_axi_rvalid = 1'b0;
        n_cmp++; if ({o_rsp_valid, o_rsp_we, m_axi_rready} !== 3'b100) begin n_err++; $display("FAIL rd_rsp_ctl got=%b exp=100", {o_rsp_valid, o_rsp_we, m_axi_rready}); end
        n_cmp++; if (o_rsp_rdata !== 64'h1234 || o_rsp_resp !== 2'b00) begin n_err++; $display("FAIL rd_rsp_data rdata=%h resp=%b exp 1234/00", o_rsp_rdata, o_rsp_resp); end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        n_cmp++; if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin n_err++; $display("FAIL rd_done got=%b exp=01", {o_rsp_valid, o_cmd_ready}); end
    endtask

    // AW ready arrives in cycle aw_d, W ready in cycle w_d (counted from the first valid cycle)
    task automatic test_write_skew(input int aw_d, input int w_d);
        int maxd;
        int n_rsp;
        maxd = (aw_d > w_d) ? aw_d : w_d;
        set_cmd(1'b1, 64'h100 + 64'(aw_d), 64'hDEAD_0000 + 64'(w_d), 8'hF0);
        tick();
        i_cmd_valid = 1'b0;
        for (int k = 0; k <= maxd; k++) begin
            m_axi_awready = (k == aw_d);
            m_axi_wready  = (k == w_d);
            tick();
            n_cmp++; if (m_axi_awvalid !== (k < aw_d) || m_axi_wvalid !== (k < w_d) || m_axi_bready !== (k >= maxd)) begin n_err++; $display("FAIL skew%0d_%0d_c%0d aw=%b w=%b b=%b exp %b %b %b", aw_d, w_d, k, m_axi_awvalid, m_axi_wvalid, m_axi_bready, (k < aw_d), (k < w_d), (k >= maxd)); end
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        tick();
        m_axi_bvalid = 1'b0;
        i_rsp_ready = 1'b1;
        n_rsp = 0;
        for (int k = 0; k < 4; k++) begin
            if (o_rsp_valid === 1'b1) n_rsp++;
            tick();
        end
        i_rsp_ready = 1'b0;
        n_cmp++; if (n_rsp !== 1) begin n_err++; $display("FAIL skew%0d_%0d_rsp_count got=%0d exp=1", aw_d, w_d, n_rsp); end
        n_cmp++; if (o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL skew%0d_%0d_idle got=%b exp=1", aw_d, w_d, o_cmd_ready); end
    endtask

    task automatic test_bresp_hold();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        set_cmd(1'b1, 64'h10, 64'h77, 8'hFF);
        tick();
        set_cmd(1'b0, 64'h20, 64'h0, 8'h00);  // next command waits with valid held
        tick();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
        tick();
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if ({o_rsp_valid, o_rsp_we, o_cmd_ready, m_axi_arvalid} !== 4'b1100 || o_rsp_resp !== 2'b10) begin n_err++; $display("FAIL hold%0d vld/we/rdy/ar=%b resp=%b exp 1100/10", k, {o_rsp_valid, o_rsp_we, o_cmd_ready, m_axi_arvalid}, o_rsp_resp); end
            tick();
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        n_cmp++; if ({o_rsp_valid, o_cmd_ready, m_axi_arvalid} !== 3'b010) begin n_err++; $display("FAIL hold_hs got=%b exp=010", {o_rsp_valid, o_cmd_ready, m_axi_arvalid}); end
        tick();
        i_cmd_valid = 1'b0;
        n_cmp++; if ({m_axi_arvalid, o_cmd_ready} !== 2'b10 || m_axi_araddr !== 64'h20) begin n_err++; $display("FAIL hold_next ar/rdy=%b araddr=%h exp 10/20", {m_axi_arvalid, o_cmd_ready}, m_axi_araddr); end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'hCAFE; m_axi_rresp = 2'b11;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
        n_cmp++; if (o_rsp_valid !== 1'b1 || o_rsp_resp !== 2'b11 || o_rsp_rdata !== 64'hCAFE) begin n_err++; $display("FAIL decerr vld=%b resp=%b rdata=%h exp 1/11/cafe", o_rsp_valid, o_rsp_resp, o_rsp_rdata); end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; i_rsp_ready = 1'b1;
        set_cmd(1'b1, 64'h30, 64'h5A, 8'h0F);
        tick();  // edge 0
        set_cmd(1'b0, 64'h40, 64'h0, 8'h00);
        tick();  // edge 1
        m_axi_bvalid = 1'b1;
        tick();  // edge 2
        m_axi_bvalid = 1'b0;
        n_cmp++; if ({o_rsp_valid, o_rsp_we, o_cmd_ready} !== 3'b110) begin n_err++; $display("FAIL b2b_wr_rsp got=%b exp=110", {o_rsp_valid, o_rsp_we, o_cmd_ready}); end
        tick();  // edge 3: response handshake
        n_cmp++; if ({o_rsp_valid, o_cmd_ready, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 5'b01000) begin n_err++; $display("FAIL b2b_gap got=%b exp=01000", {o_rsp_valid, o_cmd_ready, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}); end
        tick();  // edge 4: read accepted
        i_cmd_valid = 1'b0;
        n_cmp++; if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, o_cmd_ready} !== 4'b1000 || m_axi_araddr !== 64'h40) begin n_err++; $display("FAIL b2b_rd_start got=%b araddr=%h exp 1000/40", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, o_cmd_ready}, m_axi_araddr); end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'hBEEF; m_axi_rresp = 2'b00;
        tick();
        m_axi_rvalid = 1'b0;
        n_cmp++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 64'hBEEF || o_rsp_we !== 1'b0) begin n_err++; $display("FAIL b2b_rd_rsp vld=%b rdata=%h we=%b exp 1/beef/0", o_rsp_valid, o_rsp_rdata, o_rsp_we); end
        tick();
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        set_cmd(1'b1, 64'h50, 64'h11, 8'h01);
        tick();
        i_cmd_valid = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin n_err++; $display("FAIL abort_pre got=%b exp=11", {m_axi_awvalid, m_axi_wvalid}); end
        #2 aresetn = 1'b0;
        #1;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, o_cmd_ready} !== 3'b000) begin n_err++; $display("FAIL abort_async got=%b exp=000", {m_axi_awvalid, m_axi_wvalid, o_cmd_ready}); end
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1;
        tick(); tick();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        aresetn = 1'b1;
        #1;
        n_cmp++; if ({o_rsp_valid, o_cmd_ready, m_axi_bready} !== 3'b000) begin n_err++; $display("FAIL abort_held got=%b exp=000", {o_rsp_valid, o_cmd_ready, m_axi_bready}); end
        tick();
        n_cmp++; if ({o_cmd_ready, o_rsp_valid} !== 2'b10) begin n_err++; $display("FAIL abort_release got=%b exp=10", {o_cmd_ready, o_rsp_valid}); end
        set_cmd(1'b0, 64'h8, 64'h0, 8'h00);
        m_axi_arready = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'h55AA; m_axi_rresp = 2'b00;
        tick();
        m_axi_rvalid = 1'b0;
        n_cmp++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 64'h55AA || o_rsp_resp !== 2'b00 || o_rsp_we !== 1'b0) begin n_err++; $display("FAIL abort_read vld=%b rdata=%h resp=%b we=%b exp 1/55aa/00/0", o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_we); end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
    endtask

    // sequence of scenarios, then the summary line
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write_zero_wait();
        test_read_stall();
        test_write_skew(4, 0);
        test_write_skew(0, 4);
        test_write_skew(2, 2);
        test_bresp_hold();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
